// File: rtl/dice_pkg.sv
// Shared constants for the dice turn controller: throw width, legal face range and FSM encodings.
package dice_pkg;

   localparam int unsigned THROW_W = 3;
   localparam logic [THROW_W-1:0] FACE_MIN = 3'd1;
   localparam logic [THROW_W-1:0] FACE_MAX = 3'd6;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t ROLL   = 3'd1;
   localparam state_t SETTLE = 3'd2;
   localparam state_t REPORT = 3'd3;
   localparam state_t DONE   = 3'd4;

   // Points a face is worth; a face outside 1..6 is reported but scores nothing.
   function automatic logic [THROW_W-1:0] face_points(input logic [THROW_W-1:0] face);
      return (face >= FACE_MIN && face <= FACE_MAX) ? face : '0;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr, wrapping, as one-hot and index.
module rr_arbiter #(
   parameter int unsigned NUM_PLAYERS = 4
) (
   input  logic [NUM_PLAYERS-1:0]         req,
   input  logic [$clog2(NUM_PLAYERS)-1:0] ptr,
   output logic [NUM_PLAYERS-1:0]         gnt,
   output logic [$clog2(NUM_PLAYERS)-1:0] idx,
   output logic                           found
);

   localparam int unsigned PW = $clog2(NUM_PLAYERS);

   logic [PW-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // ptr itself is visited last, so the previous owner has the lowest priority.
      for (int unsigned i = 1; i <= NUM_PLAYERS; i++) begin
         cand = PW'((32'(ptr) + i) % NUM_PLAYERS);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/dice_turn_ctrl.sv
// Shares one dice between NUM_PLAYERS buttons: grant, roll, settle, report, score, detect winner.
// Define DICE_CTRL_DOUBLE_SIX_EN to give a bonus turn after a non-winning six.
module dice_turn_ctrl
   import dice_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS     = 4,
   parameter int unsigned SCORE_W         = 8,
   parameter int unsigned WIN_SCORE       = 30,
   parameter int unsigned MAX_ROLL_CYCLES = 1000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PLAYERS-1:0]         req,
   input  logic [THROW_W-1:0]             throw_i,
   input  logic                           new_game,
   output logic                           roll_o,
   output logic [NUM_PLAYERS-1:0]         grant_o,
   output logic                           result_valid,
   input  logic                           result_ready,
   output logic [$clog2(NUM_PLAYERS)-1:0] result_player,
   output logic [THROW_W-1:0]             result_throw,
   output logic                           timeout_o,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic                           game_over,
   output logic [$clog2(NUM_PLAYERS)-1:0] winner
);

   localparam int unsigned PW = $clog2(NUM_PLAYERS);
   localparam int unsigned CW = $clog2(MAX_ROLL_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_ROLL_CYCLES);
   localparam logic [SCORE_W-1:0] SCORE_SAT = '1;
   localparam logic [PW-1:0] PTR_INIT = PW'(NUM_PLAYERS - 1);

   state_t                 state_q, state_d;
   logic [NUM_PLAYERS-1:0] grant_q, arb_gnt;
   logic [PW-1:0]          gidx_q, ptr_q, ptr_next, arb_idx, res_player_q, winner_q;
   logic                   arb_found;
   logic [CW-1:0]          cnt_q;
   logic                   timeout_q;
   logic [THROW_W-1:0]     res_throw_q;
   logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]     base, new_score;
   logic [SCORE_W:0]       sum;
   logic                   accept, win;

   rr_arbiter #(
      .NUM_PLAYERS(NUM_PLAYERS)
   ) u_arb (
      .req  (req),
      .ptr  (ptr_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx),
      .found(arb_found)
   );

   assign roll_o        = (state_q == ROLL);
   assign result_valid  = (state_q == REPORT);
   assign game_over     = (state_q == DONE);
   assign grant_o       = grant_q;
   assign result_player = res_player_q;
   assign result_throw  = res_throw_q;
   assign timeout_o     = result_valid & timeout_q;
   assign winner        = winner_q;
   assign accept        = result_valid & result_ready;

   // A coincident new_game clears first; the accepted throw then lands on a zero score.
   always_comb begin
      base      = new_game ? '0 : score_q[gidx_q];
      sum       = {1'b0, base} + (SCORE_W + 1)'(face_points(res_throw_q));
      new_score = sum[SCORE_W] ? SCORE_SAT : sum[SCORE_W-1:0];
      win       = (32'(new_score) >= WIN_SCORE);
   end

   always_comb begin
`ifdef DICE_CTRL_DOUBLE_SIX_EN
      // Parking the pointer just behind the roller makes them first in line again.
      if (res_throw_q == FACE_MAX && !win) begin
         ptr_next = (gidx_q == '0) ? PTR_INIT : gidx_q - PW'(1);
      end else begin
         ptr_next = gidx_q;
      end
`else
      ptr_next = gidx_q;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_found) state_d = ROLL;
         ROLL:    if (!req[gidx_q] || cnt_q == CNT_MAX) state_d = SETTLE;
         SETTLE:  state_d = REPORT;
         REPORT:  if (result_ready) state_d = win ? DONE : IDLE;
         DONE:    if (new_game) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         ptr_q        <= PTR_INIT;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
         res_throw_q  <= '0;
         res_player_q <= '0;
         winner_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (arb_found) begin
                  grant_q   <= arb_gnt;
                  gidx_q    <= arb_idx;
                  cnt_q     <= CW'(1);
                  timeout_q <= 1'b0;
               end
            end
            ROLL: begin
               if (req[gidx_q]) begin
                  if (cnt_q == CNT_MAX) timeout_q <= 1'b1;
                  else                  cnt_q     <= cnt_q + CW'(1);
               end
            end
            SETTLE: begin
               res_throw_q  <= throw_i;
               res_player_q <= gidx_q;
            end
            REPORT: begin
               if (result_ready) begin
                  grant_q <= '0;
                  ptr_q   <= ptr_next;
                  if (win) winner_q <= gidx_q;
               end
            end
            DONE: begin
               if (new_game) begin
                  ptr_q    <= PTR_INIT;
                  winner_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      end else begin
         if (new_game) begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
         end
         if (accept) score_q[gidx_q] <= new_score;
      end
   end

   always_comb begin
      scores = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = score_q[i];
   end

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Self-checking bench for dice_turn_ctrl: directed scenarios plus randomized turns against a
// turn-level model of scores, rotating priority and game end.
module tb_dice_turn_ctrl;

   localparam int N    = 4;
   localparam int SW   = 5;
   localparam int SMAX = 31;
   localparam int WIN  = 30;
   localparam int MAXR = 8;

   logic            clk, rst;
   logic [N-1:0]    req;
   logic [2:0]      throw_i;
   logic            new_game;
   logic            roll_o;
   logic [N-1:0]    grant_o;
   logic            result_valid, result_ready;
   logic [1:0]      result_player;
   logic [2:0]      result_throw;
   logic            timeout_o;
   logic [N*SW-1:0] scores;
   logic            game_over;
   logic [1:0]      winner;

   int n_checks, n_fail;

   int m_score [N];
   int m_ptr;
   bit m_done;
   int m_winner;

   dice_turn_ctrl #(
      .NUM_PLAYERS    (N),
      .SCORE_W        (SW),
      .WIN_SCORE      (WIN),
      .MAX_ROLL_CYCLES(MAXR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .throw_i      (throw_i),
      .new_game     (new_game),
      .roll_o       (roll_o),
      .grant_o      (grant_o),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_player(result_player),
      .result_throw (result_throw),
      .timeout_o    (timeout_o),
      .scores       (scores),
      .game_over    (game_over),
      .winner       (winner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model (turn level) ----------------
   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_score[i] = 0;
      m_ptr    = N - 1;
      m_done   = 1'b0;
      m_winner = 0;
   endfunction

   function automatic void m_new_game();
      for (int i = 0; i < N; i++) m_score[i] = 0;
      if (m_done) begin
         m_done   = 1'b0;
         m_ptr    = N - 1;
         m_winner = 0;
      end
   endfunction

   function automatic int m_pick(input logic [N-1:0] mask);
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (m_ptr + i) % N;
         if (mask[c]) return c;
      end
      return -1;
   endfunction

   function automatic void m_accept(input int p, input int face);
      int s;
      s = m_score[p] + ((face >= 1 && face <= 6) ? face : 0);
      if (s > SMAX) s = SMAX;
      m_score[p] = s;
      m_ptr = p;
      if (s >= WIN) begin
         m_done   = 1'b1;
         m_winner = p;
      end
`ifdef DICE_CTRL_DOUBLE_SIX_EN
      else if (face == 6) m_ptr = (p + N - 1) % N;
`endif
   endfunction

   function automatic logic [N*SW-1:0] m_packed();
      logic [N*SW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*SW +: SW] = SW'(m_score[i]);
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic apply_reset();
      rst = 1'b1;
      req = '0;
      new_game = 1'b0;
      result_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      @(posedge clk);
      #1 new_game = 1'b0;
      m_new_game();
      n_checks++;
      if ({game_over, scores, winner} !== {m_done, m_packed(), 2'(m_winner)}) begin
         n_fail++;
         $display("FAIL new_game: got over=%b scores=%h winner=%0d, expected over=%b scores=%h winner=%0d",
                  game_over, scores, winner, m_done, m_packed(), m_winner);
      end
   endtask

   // One full turn from IDLE; want_p >= 0 pins the expected player, otherwise the model picks.
   task automatic do_turn(input logic [N-1:0] mask, input int hold, input logic [2:0] face,
                          input int rdelay, input bit ng_mid, input int want_p);
      int p, rolls, lat, exp_rolls;
      bit exp_to;
      logic [N-1:0] exp_gnt;
      logic [N*SW-1:0] held;
      p = (want_p >= 0) ? want_p : m_pick(mask);
      exp_gnt = N'(1 << p);
      exp_rolls = (hold > MAXR) ? MAXR : hold;
      exp_to = (hold > MAXR);
      req = mask;
      throw_i = face;
      result_ready = 1'b0;
      rolls = 0;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         new_game = (k == 1) && ng_mid;
         if (k == 1) begin
            n_checks++;
            if (grant_o !== exp_gnt) begin
               n_fail++;
               $display("FAIL grant: got %b, expected %b (req %b)", grant_o, exp_gnt, mask);
            end
            if (ng_mid) m_new_game();
         end
         if (roll_o === 1'b1) rolls++;
         if (k == hold) req = mask & ~exp_gnt;
         if (result_valid === 1'b1) lat = k;
      end
      new_game = 1'b0;
      n_checks++;
      if (lat == 0) begin
         n_fail++;
         $display("FAIL result_valid: never asserted within 40 cycles, expected after %0d",
                  exp_rolls + 2);
         req = '0;
         return;
      end
      n_checks++;
      if (rolls !== exp_rolls) begin
         n_fail++;
         $display("FAIL roll_length: got %0d cycles, expected %0d", rolls, exp_rolls);
      end
      n_checks++;
      if (lat !== exp_rolls + 2) begin
         n_fail++;
         $display("FAIL latency: got %0d cycles, expected %0d", lat, exp_rolls + 2);
      end
      n_checks++;
      if ({result_player, result_throw, timeout_o} !== {2'(p), face, exp_to}) begin
         n_fail++;
         $display("FAIL result: got player=%0d throw=%0d timeout=%b, expected %0d %0d %b",
                  result_player, result_throw, timeout_o, p, face, exp_to);
      end
      held = m_packed();
      throw_i = face ^ 3'b101;
      for (int d = 0; d < rdelay; d++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({result_valid, result_player, result_throw, timeout_o, grant_o, scores} !==
             {1'b1, 2'(p), face, exp_to, exp_gnt, held}) begin
            n_fail++;
            $display("FAIL hold: got v=%b p=%0d t=%0d to=%b g=%b s=%h, expected 1 %0d %0d %b %b %h",
                     result_valid, result_player, result_throw, timeout_o, grant_o, scores,
                     p, face, exp_to, exp_gnt, held);
         end
      end
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      req = '0;
      m_accept(p, int'(face));
      n_checks++;
      if ({result_valid, grant_o} !== {1'b0, {N{1'b0}}}) begin
         n_fail++;
         $display("FAIL accept_clear: got valid=%b grant=%b, expected 0 0", result_valid, grant_o);
      end
      n_checks++;
      if ({scores, game_over, winner} !== {m_packed(), m_done, 2'(m_winner)}) begin
         n_fail++;
         $display("FAIL score: got scores=%h over=%b winner=%0d, expected %h %b %0d",
                  scores, game_over, winner, m_packed(), m_done, m_winner);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({roll_o, grant_o, result_valid, timeout_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got roll=%b grant=%b valid=%b to=%b, expected all 0",
                  roll_o, grant_o, result_valid, timeout_o);
      end
      n_checks++;
      if ({scores, game_over, winner} !== '0) begin
         n_fail++;
         $display("FAIL reset_score: got scores=%h over=%b winner=%0d, expected 0",
                  scores, game_over, winner);
      end
      apply_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({grant_o, roll_o} !== '0) begin
         n_fail++;
         $display("FAIL idle_quiet: got grant=%b roll=%b, expected 0", grant_o, roll_o);
      end
   endtask

   task automatic test_single();
      do_turn(4'b0001, 5, 3'd4, 0, 1'b0, 0);
      n_checks++;
      if (scores[SW-1:0] !== 5'd4) begin
         n_fail++;
         $display("FAIL single_score: got %0d, expected 4", scores[SW-1:0]);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int t = 0; t < 5; t++) do_turn(4'b1111, 2, 3'd2, 0, 1'b0, t % N);
      n_checks++;
      if (scores !== {5'd2, 5'd2, 5'd2, 5'd4}) begin
         n_fail++;
         $display("FAIL rr_scores: got %h, expected %h", scores, {5'd2, 5'd2, 5'd2, 5'd4});
      end
   endtask

   task automatic test_backpressure();
      do_turn(4'b0100, 3, 3'd5, 10, 1'b0, 2);
   endtask

   task automatic test_timeout();
      do_turn(4'b0010, 20, 3'd3, 2, 1'b0, 1);
   endtask

   task automatic test_out_of_range();
      do_turn(4'b1000, 2, 3'd7, 1, 1'b0, -1);
      do_turn(4'b1000, 1, 3'd0, 0, 1'b0, -1);
   endtask

   task automatic test_game_over();
      apply_reset();
      for (int t = 0; t < 4; t++) do_turn(4'b0010, 1, 3'd6, 0, 1'b0, 1);
      do_turn(4'b0010, 1, 3'd4, 0, 1'b0, 1);
      do_turn(4'b0010, 2, 3'd3, 0, 1'b0, 1);
      n_checks++;
      if ({game_over, winner, scores[SW +: SW]} !== {1'b1, 2'd1, 5'd31}) begin
         n_fail++;
         $display("FAIL game_over: got over=%b winner=%0d score1=%0d, expected 1 1 31",
                  game_over, winner, scores[SW +: SW]);
      end
      req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({grant_o, roll_o, game_over} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL done_ignore: got grant=%b roll=%b over=%b, expected 0000 0 1",
                     grant_o, roll_o, game_over);
         end
      end
      req = '0;
      pulse_new_game();
      do_turn(4'b1111, 1, 3'd1, 0, 1'b0, 0);
   endtask

   task automatic test_double_six();
      int want;
`ifdef DICE_CTRL_DOUBLE_SIX_EN
      want = 0;
`else
      want = 1;
`endif
      apply_reset();
      do_turn(4'b1111, 1, 3'd6, 0, 1'b0, 0);
      do_turn(4'b1111, 1, 3'd2, 0, 1'b0, want);
   endtask

   task automatic test_reset_midturn();
      req = 4'b1000;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (roll_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midturn_roll: got roll=%b, expected 1", roll_o);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({roll_o, grant_o, result_valid, scores} !== '0) begin
         n_fail++;
         $display("FAIL midturn_reset: got roll=%b grant=%b valid=%b scores=%h, expected 0",
                  roll_o, grant_o, result_valid, scores);
      end
      apply_reset();
      do_turn(4'b1000, 1, 3'd5, 0, 1'b0, 3);
   endtask

   task automatic test_random();
      apply_reset();
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] mask;
         if (m_done) pulse_new_game();
         mask = N'($urandom_range(1, 15));
         do_turn(mask, $urandom_range(1, 12), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0), -1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b0;
      req = '0;
      throw_i = '0;
      new_game = 1'b0;
      result_ready = 1'b0;
      m_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_out_of_range();
      test_game_over();
      test_double_six();
      test_reset_midturn();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
